// File: rtl/rf_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with busy scoreboard.
// Imported by the interface, the read-port sub-module and the top.
package rf_pkg;
    localparam int RF_DATA_W     = 32;
    localparam int RF_ADDR_W     = 5;
    localparam int RF_NUM_RD     = 2;
    localparam int RF_MAX_ADDR_W = 16;

    // Callers zero-extend their address to RF_MAX_ADDR_W before calling.
    function automatic logic rf_is_zero(input logic [RF_MAX_ADDR_W-1:0] addr,
                                        input logic                     zero_reg);
        return zero_reg && (addr == '0);
    endfunction
endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write port,
// reservation request/grant, flush and busy count.
interface rf_scoreboard_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_grant;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, rsv_grant, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, rsv_grant, busy_cnt
    );
endinterface

// File: rtl/rf_scoreboard_read_port.sv
// One combinational read port: register mux, zero-register masking and, when
// RF_BYPASS_EN is defined, same-cycle forwarding of the write port.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
    input  logic [(1<<ADDR_W)-1:0]             busy,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [ADDR_W-1:0]                  addr,
    output logic [DATA_W-1:0]                  data,
    output logic                               reg_busy
);
    logic zero_hit;
    assign zero_hit = rf_is_zero(RF_MAX_ADDR_W'(addr), ZERO_REG);

`ifdef RF_BYPASS_EN
    logic fwd;
    assign fwd = wr_en && (wr_addr == addr) && !zero_hit;

    always_comb begin
        data     = mem[addr];
        reg_busy = busy[addr];
        if (zero_hit) begin
            data     = '0;
            reg_busy = 1'b0;
        end else if (fwd) begin
            // The write also releases the register, so the forwarded value is not busy.
            data     = wr_data;
            reg_busy = 1'b0;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        data     = mem[addr];
        reg_busy = busy[addr];
        if (zero_hit) begin
            data     = '0;
            reg_busy = 1'b0;
        end
    end
`endif
endmodule

// File: rtl/rf_scoreboard.sv
// Register file with NUM_RD combinational read ports, one write port and a busy
// scoreboard for multi-cycle destinations; optional write bypass via RF_BYPASS_EN.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    rf_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic [ADDR_W:0]              cnt;

    logic wr_zero;
    logic rsv_zero;
    logic grant;
    logic rsv_set;
    logic wr_clr;

    assign wr_zero  = rf_is_zero(RF_MAX_ADDR_W'(bus.wr_addr), ZERO_REG);
    assign rsv_zero = rf_is_zero(RF_MAX_ADDR_W'(bus.rsv_addr), ZERO_REG);

    assign grant   = bus.rsv_en & ~rst & ~bus.flush & (~busy[bus.rsv_addr] | rsv_zero);
    assign rsv_set = grant & ~rsv_zero;
    // A granted reservation implies its target is idle, so a same-address write cannot also clear.
    assign wr_clr  = bus.wr_en & ~wr_zero & busy[bus.wr_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem  <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (bus.wr_en && !wr_zero) begin
                mem[bus.wr_addr]  <= bus.wr_data;
                busy[bus.wr_addr] <= 1'b0;
            end
            // Later assignments win: flush beats everything, reservation beats write release.
            if (bus.flush) begin
                busy <= '0;
            end else if (rsv_set) begin
                busy[bus.rsv_addr] <= 1'b1;
            end

            if (bus.flush) begin
                cnt <= '0;
            end else if (rsv_set && !wr_clr) begin
                cnt <= cnt + 1'b1;
            end else if (wr_clr && !rsv_set) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.rsv_grant = grant;
    assign bus.busy_cnt  = cnt;

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_w;
    logic [NUM_RD-1:0]             rd_busy_w;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .mem      (mem),
            .busy     (busy),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .addr     (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .data     (rd_data_w[k]),
            .reg_busy (rd_busy_w[k])
        );
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed scoreboard bench for rf_scoreboard (default parameters, ZERO_REG=1).
module tb_rf_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk;
    logic rst;

    rf_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_v(input string tag, input logic [63:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic chk(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: observed %0h with no expected value", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic idle();
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
        bus.flush  = 1'b0;
    endtask

    function automatic logic [DW-1:0] rd0();
        return bus.rd_data[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rd1();
        return bus.rd_data[2*DW-1:DW];
    endfunction

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd3;
        bus.flush    = 1'b0;

        // Reset state, with a reservation request held during reset.
        expect_v("rst_grant", 0);
        expect_v("rst_cnt", 0);
        expect_v("rst_data", 0);
        expect_v("rst_busy", 0);
        #3;
        chk(64'(bus.rsv_grant));
        chk(64'(bus.busy_cnt));
        chk(64'(rd0()));
        chk(64'(bus.rd_busy));
        bus.rsv_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write r5 and reserve r7 together, then reset mid-cycle.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
        expect_v("pre_rst_data_r5", 64'hDEADBEEF);
        expect_v("pre_rst_busy_r7", 1);
        expect_v("pre_rst_cnt", 1);
        tick();
        idle();
        set_rd(5'd5, 5'd7);
        #1;
        chk(64'(rd0()));
        chk(64'(bus.rd_busy[1]));
        chk(64'(bus.busy_cnt));
        rst = 1'b1;
        expect_v("mid_rst_data_r5", 0);
        expect_v("mid_rst_busy_r7", 0);
        expect_v("mid_rst_cnt", 0);
        #1;
        chk(64'(rd0()));
        chk(64'(bus.rd_busy[1]));
        chk(64'(bus.busy_cnt));
        @(negedge clk);
        rst = 1'b0;

        // Double reservation of r3, released by a write.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        set_rd(5'd3, 5'd0);
        expect_v("r3_grant1", 1);
        #1;
        chk(64'(bus.rsv_grant));
        tick();
        expect_v("r3_grant2", 0);
        expect_v("r3_busy", 1);
        expect_v("r3_cnt", 1);
        chk(64'(bus.rsv_grant));
        chk(64'(bus.rd_busy[0]));
        chk(64'(bus.busy_cnt));
        tick();
        idle();
        expect_v("r3_busy_hold", 1);
        expect_v("r3_cnt_hold", 1);
        chk(64'(bus.rd_busy[0]));
        chk(64'(bus.busy_cnt));
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h12;
        expect_v("r3_release_busy", 0);
        expect_v("r3_release_data", 64'h12);
        expect_v("r3_release_cnt", 0);
        tick();
        idle();
        chk(64'(bus.rd_busy[0]));
        chk(64'(rd0()));
        chk(64'(bus.busy_cnt));

        // Same-cycle write and reserve of r9: data lands, reservation wins.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h55;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
        expect_v("r9_grant", 1);
        expect_v("r9_data", 64'h55);
        expect_v("r9_busy", 1);
        expect_v("r9_cnt", 1);
        #1;
        chk(64'(bus.rsv_grant));
        tick();
        idle();
        set_rd(5'd9, 5'd0);
        #1;
        chk(64'(rd0()));
        chk(64'(bus.rd_busy[0]));
        chk(64'(bus.busy_cnt));

        // Release and reserve different registers in one cycle: net count change 0.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd20;
        tick();
        bus.rsv_addr = 5'd21;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'h0;
        expect_v("swap_cnt", 2);
        expect_v("swap_busy_r20", 0);
        expect_v("swap_busy_r21", 1);
        tick();
        idle();
        set_rd(5'd20, 5'd21);
        #1;
        chk(64'(bus.busy_cnt));
        chk(64'(bus.rd_busy[0]));
        chk(64'(bus.rd_busy[1]));

        // Reserve r1, r2, r4, then flush with a reserve of r6.
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd1;
        tick();
        bus.rsv_addr = 5'd2;
        tick();
        bus.rsv_addr = 5'd4;
        tick();
        expect_v("pre_flush_cnt", 5);
        chk(64'(bus.busy_cnt));
        bus.rsv_addr = 5'd6;
        bus.flush = 1'b1;
        expect_v("flush_grant", 0);
        expect_v("flush_cnt", 0);
        expect_v("flush_busy_r1_r6", 0);
        expect_v("flush_busy_r4_r9", 0);
        #1;
        chk(64'(bus.rsv_grant));
        tick();
        idle();
        set_rd(5'd1, 5'd6);
        #1;
        chk(64'(bus.busy_cnt));
        chk(64'(bus.rd_busy));
        set_rd(5'd4, 5'd9);
        #1;
        chk(64'(bus.rd_busy));

        // Register 0: writes ignored, reservation granted without effect.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        expect_v("r0_grant", 1);
        expect_v("r0_data", 0);
        expect_v("r0_busy", 0);
        expect_v("r0_cnt", 0);
        #1;
        chk(64'(bus.rsv_grant));
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        #1;
        chk(64'(rd0()));
        chk(64'(bus.rd_busy[0]));
        chk(64'(bus.busy_cnt));

        // Write-to-read on the same port, with and without bypass.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h1111;
        tick();
        idle();
        set_rd(5'd0, 5'd12);
        bus.wr_en = 1'b1; bus.wr_data = 32'hA5A5;
`ifdef RF_BYPASS_EN
        expect_v("r12_same_cycle", 64'hA5A5);
`else
        expect_v("r12_same_cycle", 64'h1111);
`endif
        expect_v("r12_next_cycle", 64'hA5A5);
        #1;
        chk(64'(rd1()));
        tick();
        idle();
        #1;
        chk(64'(rd1()));

        expect_v("queue_drained", 0);
        chk(64'(exp_q.size() - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
